mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-side access sequencer directly downstream of the datapath's MAR/MDR pair.
- Takes single-word read/write requests from the control unit, drives a ready-handshaked memory port with wait-state tolerance, and returns read data on M_bus_in with a one-cycle MMD load strobe.
- Detects misaligned addresses, request conflicts and memory timeouts. Reports them to the control unit as a bus error.

Parameters:
- TIMEOUT_CYCLES, 15: maximum RD/WR-state cycles waiting for mem_ready before a timeout error (minimum 1).
- ALIGN_CHECK, 1: when 1, an odd address (MAR_in[0]=1) raises a misalign error; when 0, bit 0 is passed through unchecked.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  asynchronous active-high reset.
- MAR_in  in  16  address from the datapath MAR.
- MDR_in  in  16  write data from the datapath MDR (Mbus output side).
- rd_req  in  1  read request, sampled in IDLE only.
- wr_req  in  1  write request, sampled in IDLE only.
- err_clr  in  1  clears err_flag/err_code.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_re  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_rdata  in  16  memory read data.
- mem_ready  in  1  memory completion strobe.
- M_bus_in  out  16  latched read data toward the MDR.
- MMD  out  1  MDR load strobe (Mbus to MDR), one cycle.
- busy  out  1  high whenever state is not IDLE; the control unit stalls on it.
- done  out  1  one-cycle successful-completion pulse.
- bus_err  out  1  one-cycle error pulse.
- err_flag  out  1  sticky error flag.
- err_code  out  2  00 none, 01 timeout, 10 misalign, 11 rd/wr conflict.

Behaviour:
- Reset: asynchronous on CLR high; takes effect immediately, including mid-access.
  - State goes to IDLE.
  - All outputs go to 0: mem_re, mem_we, MMD, done, bus_err, err_flag, err_code, M_bus_in, mem_addr, mem_wdata, wait counter.
- States: IDLE, RD, WR, RD_DONE, WR_DONE, ERR.
- IDLE transitions:
  - rd_req and wr_req both high: go to ERR, code 11, no memory access.
  - Either request high with ALIGN_CHECK=1 and MAR_in[0]=1: go to ERR, code 10.
  - rd_req alone: latch MAR_in into mem_addr, clear counter, go to RD.
  - wr_req alone: latch MAR_in into mem_addr and MDR_in into mem_wdata, clear counter, go to WR.
  - mem_ready is ignored in IDLE.
- RD:
  - mem_re=1 throughout; mem_addr held stable.
  - mem_ready=1: capture mem_rdata into the M_bus_in register, go to RD_DONE.
  - Otherwise the counter increments. If the counter reaches TIMEOUT_CYCLES-1 without ready, go to ERR, code 01.
  - mem_ready on the final allowed cycle wins over timeout.
- WR: mem_we=1 and mem_wdata held. On mem_ready go to WR_DONE. Timeout rules are identical to RD.
- RD_DONE: MMD=1 and done=1 for one cycle, then IDLE.
- WR_DONE: done=1 for one cycle, then IDLE.
- ERR: bus_err=1 for one cycle, err_flag set, err_code loaded, then IDLE. done is never asserted on an error.
- M_bus_in holds the last successfully read word until the next successful read. A timed-out read leaves it unchanged.
- mem_re and mem_we are never high together. Both are registered outputs, glitch-free.
- Requests arriving while busy or during a DONE/ERR cycle are ignored, not queued.
- err_clr: clears err_flag and err_code in any state.
  - If err_clr and a new error occur in the same cycle, the new error wins.
  - A later error overwrites err_code.
- Latency, zero-wait memory (ready in first RD cycle): request sampled at edge n, RD in cycle n+1, MMD/done in cycle n+2; the MDR loads at edge n+3. Each wait cycle adds 1.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

Decomposition:
- Shared package (mem_if_pkg): state encoding enum, ERR_* code localparams (NONE/TIMEOUT/MISALIGN/CONFLICT), default TIMEOUT_CYCLES.
- One natural sub-module, wait_timer: counter with clear, enable, saturate and an expired output. It is reusable by the H6 multiply sequencer.
- The FSM and data latches stay in mem_access_ctrl.

Test Plan:
- Zero-wait read: MAR_in=0x0100, rd_req 1 cycle, mem_ready with mem_rdata=0xBEEF on the first RD cycle -> mem_re high 1 cycle; MMD=done=1 exactly 2 cycles after the request; M_bus_in=0xBEEF held afterwards.
- Write with 3 wait states: MAR_in=0x0202, MDR_in=0x1234 -> mem_we high 4 cycles with mem_addr=0x0202 and mem_wdata=0x1234 stable; done 1 cycle after ready; MMD stays 0.
- Timeout: TIMEOUT_CYCLES=15, rd_req, mem_ready held 0 -> bus_err after 15 RD cycles; err_code=01, err_flag=1; M_bus_in unchanged; err_clr -> both cleared.
- Misalign and conflict:
  - rd_req with MAR_in=0x0101 -> ERR, err_code=10, mem_re never asserted.
  - rd_req and wr_req together -> err_code=11, no memory enable.
- Reset mid-access: CLR asserted during the 2nd WR wait cycle -> mem_we drops asynchronously, all outputs 0; a read afterwards completes normally.
- Busy masking: a second rd_req during RD is ignored; mem_ready arriving on the 15th cycle completes the read with no bus_err.

Source files
------------

// File: rtl/mem_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_if_pkg : shared state encoding and error codes for the memory sequencer
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_WR      = 3'd2,
    ST_RD_DONE = 3'd3,
    ST_WR_DONE = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;
  localparam logic [1:0] ERR_CONFLICT = 2'b11;

  localparam int DEF_TIMEOUT_CYCLES = 15;

endpackage : mem_if_pkg

`default_nettype wire

// File: rtl/wait_timer.sv
// ---------------------------------------------------------------------------
// wait_timer : saturating wait-state counter with clear, enable and expiry flag
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] SAT  = CW'(LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires while the counter sits on the last allowed wait cycle.
  assign expired_o = (cnt_q >= LAST);

endmodule : wait_timer

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl : MAR/MDR-side single-word memory access sequencer
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_ctrl
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int ALIGN_CHECK    = 1
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [15:0] MAR_in,
  input  logic [15:0] MDR_in,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic        err_clr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] M_bus_in,
  output logic        MMD,
  output logic        busy,
  output logic        done,
  output logic        bus_err,
  output logic        err_flag,
  output logic [1:0]  err_code
);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_flag_q, err_flag_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        re_q, we_q, mmd_q, done_q, berr_q;

  logic w_misalign;
  logic w_in_access;
  logic w_expired;

  generate
    if (ALIGN_CHECK != 0) begin : g_align
      assign w_misalign = MAR_in[0];
    end else begin : g_no_align
      assign w_misalign = 1'b0;
    end
  endgenerate

  assign w_in_access = (state_q == ST_RD) || (state_q == ST_WR);

  wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i     (CLK),
    .rst_i     (CLR),
    .clr_i     (!w_in_access),
    .en_i      (w_in_access && !mem_ready),
    .expired_o (w_expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_flag_d = err_flag_q;
    err_code_d = err_code_q;

    // Applied first so an error raised in the same cycle overrides the clear.
    if (err_clr) begin
      err_flag_d = 1'b0;
      err_code_d = ERR_NONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (rd_req && wr_req) begin
          state_d    = ST_ERR;
          err_flag_d = 1'b1;
          err_code_d = ERR_CONFLICT;
        end else if ((rd_req || wr_req) && w_misalign) begin
          state_d    = ST_ERR;
          err_flag_d = 1'b1;
          err_code_d = ERR_MISALIGN;
        end else if (rd_req) begin
          addr_d  = MAR_in;
          state_d = ST_RD;
        end else if (wr_req) begin
          addr_d  = MAR_in;
          wdata_d = MDR_in;
          state_d = ST_WR;
        end
      end
      ST_RD: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = ST_RD_DONE;
        end else if (w_expired) begin
          state_d    = ST_ERR;
          err_flag_d = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_WR: begin
        if (mem_ready) begin
          state_d = ST_WR_DONE;
        end else if (w_expired) begin
          state_d    = ST_ERR;
          err_flag_d = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_RD_DONE, ST_WR_DONE, ST_ERR: state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they align with it.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_flag_q <= 1'b0;
      err_code_q <= ERR_NONE;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      mmd_q      <= 1'b0;
      done_q     <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_flag_q <= err_flag_d;
      err_code_q <= err_code_d;
      re_q       <= (state_d == ST_RD);
      we_q       <= (state_d == ST_WR);
      mmd_q      <= (state_d == ST_RD_DONE);
      done_q     <= (state_d == ST_RD_DONE) || (state_d == ST_WR_DONE);
      berr_q     <= (state_d == ST_ERR);
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign M_bus_in  = rdata_q;
  assign MMD       = mmd_q;
  assign done      = done_q;
  assign bus_err   = berr_q;
  assign err_flag  = err_flag_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != ST_IDLE);

endmodule : mem_access_ctrl

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl : directed self-checking bench for mem_access_ctrl
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        CLR = 1'b1;
  logic [15:0] MAR_in = '0, MDR_in = '0, mem_rdata = '0;
  logic        rd_req = 1'b0, wr_req = 1'b0, err_clr = 1'b0, mem_ready = 1'b0;
  logic [15:0] mem_addr, mem_wdata, M_bus_in;
  logic        mem_re, mem_we, MMD, busy, done, bus_err, err_flag;
  logic [1:0]  err_code;
  logic [5:0]  ctl;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(15), .ALIGN_CHECK(1)) dut (
    .CLK(clk), .CLR(CLR), .MAR_in(MAR_in), .MDR_in(MDR_in),
    .rd_req(rd_req), .wr_req(wr_req), .err_clr(err_clr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .M_bus_in(M_bus_in), .MMD(MMD),
    .busy(busy), .done(done), .bus_err(bus_err), .err_flag(err_flag), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // ctl bit order: busy, mem_re, mem_we, MMD, done, bus_err
  assign ctl = {busy, mem_re, mem_we, MMD, done, bus_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (ctl !== 6'b0 || err_flag !== 1'b0 || err_code !== 2'b00) begin
      errors++; $display("FAIL reset_ctl: ctl=%b flag=%b code=%b want 000000/0/00", ctl, err_flag, err_code);
    end
    checks++;
    if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || M_bus_in !== 16'h0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h mbus=%h want 0/0/0", mem_addr, mem_wdata, M_bus_in);
    end
    CLR = 1'b0;
    tick();
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ready = 1'b0; mem_rdata = 16'h0;
    checks++;
    if (ctl !== 6'b0 || M_bus_in !== 16'h0) begin
      errors++; $display("FAIL idle_ready_ignored: ctl=%b mbus=%h want 000000/0000", ctl, M_bus_in);
    end
  endtask

  task automatic test_zero_wait_read();
    MAR_in = 16'h0100; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++;
    if (ctl !== 6'b110000 || mem_addr !== 16'h0100) begin
      errors++; $display("FAIL zw_rd_cycle: ctl=%b addr=%h want 110000/0100", ctl, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ready = 1'b0; mem_rdata = 16'h0;
    checks++;
    if (ctl !== 6'b100110 || M_bus_in !== 16'hBEEF) begin
      errors++; $display("FAIL zw_rd_done: ctl=%b mbus=%h want 100110/beef", ctl, M_bus_in);
    end
    repeat (2) tick();
    checks++;
    if (ctl !== 6'b0 || M_bus_in !== 16'hBEEF) begin
      errors++; $display("FAIL zw_rd_hold: ctl=%b mbus=%h want 000000/beef", ctl, M_bus_in);
    end
  endtask

  task automatic test_write_wait();
    MAR_in = 16'h0202; MDR_in = 16'h1234; wr_req = 1'b1;
    tick();
    wr_req = 1'b0; MAR_in = 16'hFFF0; MDR_in = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ctl !== 6'b101000 || mem_addr !== 16'h0202 || mem_wdata !== 16'h1234) begin
        errors++; $display("FAIL wr_wait%0d: ctl=%b addr=%h wdata=%h want 101000/0202/1234", i, ctl, mem_addr, mem_wdata);
      end
      mem_ready = (i == 3);
      tick();
    end
    mem_ready = 1'b0;
    checks++;
    if (ctl !== 6'b100010 || err_flag !== 1'b0) begin
      errors++; $display("FAIL wr_done: ctl=%b flag=%b want 100010/0", ctl, err_flag);
    end
    tick();
    checks++;
    if (ctl !== 6'b0) begin
      errors++; $display("FAIL wr_idle: ctl=%b want 000000", ctl);
    end
  endtask

  task automatic test_timeout();
    MAR_in = 16'h0300; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      checks++;
      if (ctl !== 6'b110000) begin
        errors++; $display("FAIL to_wait%0d: ctl=%b want 110000", i, ctl);
      end
      tick();
    end
    checks++;
    if (ctl !== 6'b100001 || err_code !== 2'b01 || err_flag !== 1'b1 || M_bus_in !== 16'hBEEF) begin
      errors++; $display("FAIL to_err: ctl=%b code=%b flag=%b mbus=%h want 100001/01/1/beef", ctl, err_code, err_flag, M_bus_in);
    end
    tick();
    checks++;
    if (ctl !== 6'b0 || err_flag !== 1'b1 || err_code !== 2'b01) begin
      errors++; $display("FAIL to_sticky: ctl=%b flag=%b code=%b want 000000/1/01", ctl, err_flag, err_code);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_flag !== 1'b0 || err_code !== 2'b00) begin
      errors++; $display("FAIL to_clr: flag=%b code=%b want 0/00", err_flag, err_code);
    end
  endtask

  task automatic test_misalign_conflict();
    MAR_in = 16'h0101; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++;
    if (ctl !== 6'b100001 || err_code !== 2'b10 || err_flag !== 1'b1) begin
      errors++; $display("FAIL misalign_err: ctl=%b code=%b flag=%b want 100001/10/1", ctl, err_code, err_flag);
    end
    tick();
    checks++;
    if (ctl !== 6'b0 || err_code !== 2'b10) begin
      errors++; $display("FAIL misalign_idle: ctl=%b code=%b want 000000/10", ctl, err_code);
    end
    // Clear and a fresh conflict in the same cycle: the conflict must win.
    MAR_in = 16'h0400; rd_req = 1'b1; wr_req = 1'b1; err_clr = 1'b1;
    tick();
    rd_req = 1'b0; wr_req = 1'b0; err_clr = 1'b0;
    checks++;
    if (ctl !== 6'b100001 || err_code !== 2'b11 || err_flag !== 1'b1) begin
      errors++; $display("FAIL conflict_err: ctl=%b code=%b flag=%b want 100001/11/1", ctl, err_code, err_flag);
    end
    tick();
    checks++;
    if (ctl !== 6'b0) begin
      errors++; $display("FAIL conflict_idle: ctl=%b want 000000", ctl);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    MAR_in = 16'h0500; MDR_in = 16'hAAAA; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    tick();
    checks++;
    if (ctl !== 6'b101000) begin
      errors++; $display("FAIL rst_mid_pre: ctl=%b want 101000", ctl);
    end
    #2 CLR = 1'b1;
    #1;
    checks++;
    if (ctl !== 6'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0 || M_bus_in !== 16'h0 || err_code !== 2'b00) begin
      errors++; $display("FAIL rst_mid_async: ctl=%b addr=%h wdata=%h mbus=%h code=%b want all 0", ctl, mem_addr, mem_wdata, M_bus_in, err_code);
    end
    #2 CLR = 1'b0;
    tick();
    MAR_in = 16'h0600; rd_req = 1'b1;
    tick();
    rd_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_ready = 1'b0; mem_rdata = 16'h0;
    checks++;
    if (ctl !== 6'b100110 || M_bus_in !== 16'h5A5A || mem_addr !== 16'h0600) begin
      errors++; $display("FAIL rst_then_rd: ctl=%b mbus=%h addr=%h want 100110/5a5a/0600", ctl, M_bus_in, mem_addr);
    end
    tick();
  endtask

  task automatic test_busy_masking();
    MAR_in = 16'h0700; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      checks++;
      if (ctl !== 6'b110000 || mem_addr !== 16'h0700) begin
        errors++; $display("FAIL mask_wait%0d: ctl=%b addr=%h want 110000/0700", i, ctl, mem_addr);
      end
      rd_req = (i == 3);
      MAR_in = (i == 3) ? 16'h0701 : 16'h0700;
      mem_ready = (i == 15);
      mem_rdata = (i == 15) ? 16'hC3C3 : 16'h0;
      tick();
    end
    mem_ready = 1'b0; mem_rdata = 16'h0;
    checks++;
    if (ctl !== 6'b100110 || M_bus_in !== 16'hC3C3 || err_flag !== 1'b0) begin
      errors++; $display("FAIL mask_done: ctl=%b mbus=%h flag=%b want 100110/c3c3/0", ctl, M_bus_in, err_flag);
    end
    tick();
    checks++;
    if (ctl !== 6'b0 || err_code !== 2'b00) begin
      errors++; $display("FAIL mask_idle: ctl=%b code=%b want 000000/00", ctl, err_code);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_timeout();
    test_misalign_conflict();
    test_reset_mid_access();
    test_busy_masking();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_access_ctrl

`default_nettype wire
